alu_seq: RTL

- Parametrised, registered ALU; successor to the 4-bit combinational ALU.
- Adds a valid/ready handshake on input and output, a registered result with status flags, and a multi-cycle shift-add multiply.
- Sits between an operand source (register file or sequencer) and a result sink that may apply backpressure.

---
 rtl/alu_pkg.sv | 18 +
 rtl/alu_mul_seq.sv | 55 +++++
 rtl/alu_seq.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcode and FSM-state definitions for the sequential ALU and its testbench.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Unsigned shift-add multiplier: one iteration per clock, WIDTH iterations after start.
// done and product are combinational so the caller can register the result on the final edge.
module alu_mul_seq #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] ITERS = CW'(WIDTH);

    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH:0]     sum;

    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    always_comb begin
        // Upper half accumulates, lower half holds the not-yet-consumed multiplier bits.
        sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        product = {sum, acc_q[WIDTH-1:1]};
        done    = (cnt_q == CW'(1));
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        if (start) begin
            cnt_d   = ITERS;
            acc_d   = {{WIDTH{1'b0}}, b};
            mcand_d = a;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
            acc_d = product;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            acc_q   <= '0;
            mcand_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes on both sides and a multi-cycle multiply.
// Single-cycle ops have latency 1; MUL has latency WIDTH with in_ready low throughout.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] yh,
    output logic             c,
    output logic             v,
    output logic             z,
    output logic             n,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [WIDTH:0] WIDTH_V = (WIDTH + 1)'(WIDTH);

    state_t             state_q, state_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   y_q, y_d, yh_q, yh_d;
    logic               c_q, c_d, v_q, v_d, z_q, z_d, n_q, n_d;

    logic               accept, mul_start, mul_done;
    logic [2*WIDTH-1:0] mul_product;
    logic [WIDTH-1:0]   op_y;
    logic               op_c, op_v, shift_ok;
    logic [WIDTH:0]     add_ext, sub_ext, shl_ext, shr_ext;

    assign in_ready  = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (sel == OP_MUL);

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_product)
    );

    // Extra bit on each side catches carry/borrow and the last bit shifted out.
    always_comb begin
        add_ext  = {1'b0, a} + {1'b0, b};
        sub_ext  = {1'b0, a} - {1'b0, b};
        shl_ext  = {1'b0, a} << b[SHW-1:0];
        shr_ext  = {a, 1'b0} >> b[SHW-1:0];
        shift_ok = ({1'b0, b} < WIDTH_V);
        op_y     = '0;
        op_c     = 1'b0;
        op_v     = 1'b0;
        case (sel)
            OP_ADD: begin
                {op_c, op_y} = add_ext;
                op_v = (a[WIDTH-1] == b[WIDTH-1]) && (add_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                {op_c, op_y} = sub_ext;
                op_v = (a[WIDTH-1] != b[WIDTH-1]) && (sub_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: op_y = a & b;
            OP_OR:  op_y = a | b;
            OP_XOR: op_y = a ^ b;
            OP_SHL: if (shift_ok) {op_c, op_y} = shl_ext;
            OP_SHR: if (shift_ok) {op_y, op_c} = shr_ext;
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        y_d         = y_q;
        yh_d        = yh_q;
        c_d         = c_q;
        v_d         = v_q;
        z_d         = z_q;
        n_d         = n_q;
        if (out_valid_q && out_ready) out_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (sel == OP_MUL) begin
                        state_d     = ST_MUL;
                        out_valid_d = 1'b0;
                    end else begin
                        out_valid_d = 1'b1;
                        y_d         = op_y;
                        yh_d        = '0;
                        c_d         = op_c;
                        v_d         = op_v;
                        z_d         = (op_y == '0);
                        n_d         = op_y[WIDTH-1];
                    end
                end
            end
            ST_MUL: begin
                if (mul_done) begin
                    state_d      = ST_IDLE;
                    out_valid_d  = 1'b1;
                    {yh_d, y_d}  = mul_product;
                    c_d          = |mul_product[2*WIDTH-1:WIDTH];
                    v_d          = 1'b0;
                    z_d          = (mul_product == '0);
                    n_d          = mul_product[WIDTH-1];
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            y_q         <= '0;
            yh_q        <= '0;
            c_q         <= 1'b0;
            v_q         <= 1'b0;
            z_q         <= 1'b0;
            n_q         <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            y_q         <= y_d;
            yh_q        <= yh_d;
            c_q         <= c_d;
            v_q         <= v_d;
            z_q         <= z_d;
            n_q         <= n_d;
        end
    end

    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign yh        = yh_q;
    assign c         = c_q;
    assign v         = v_q;
    assign z         = z_q;
    assign n         = n_q;

endmodule
